// File: rtl/plru_if.sv
// Request/response bundle for the tree-PLRU replacement array.
// req_vmask exists only when PLRU_INVALID_FIRST_EN is defined.
interface plru_if #(
   parameter int ASSOC    = 8,
   parameter int NUM_SETS = 64
);
   localparam int WW = $clog2(ASSOC);
   localparam int SW = $clog2(NUM_SETS);

   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [SW-1:0]     req_set;
   logic [WW-1:0]     req_way;
`ifdef PLRU_INVALID_FIRST_EN
   logic [ASSOC-1:0]  req_vmask;
`endif
   logic              resp_valid;
   logic [WW-1:0]     resp_way;
   logic [ASSOC-2:0]  resp_lru;

   modport master (
`ifdef PLRU_INVALID_FIRST_EN
      output req_vmask,
`endif
      output req_valid, req_op, req_set, req_way,
      input  req_ready, resp_valid, resp_way, resp_lru
   );

   modport slave (
`ifdef PLRU_INVALID_FIRST_EN
      input  req_vmask,
`endif
      input  req_valid, req_op, req_set, req_way,
      output req_ready, resp_valid, resp_way, resp_lru
   );
endinterface

// File: rtl/plru_array.sv
// Per-set tree-PLRU state with a 2-stage touch/alloc/peek pipeline.
// Optional PLRU_INVALID_FIRST_EN: ALLOC/PEEK prefer the lowest invalid way.
//
// state | meaning
// INIT  | zeroing one set per cycle, req_ready low
// READY | accepting one request per cycle
module plru_array #(
   parameter int ASSOC    = 8,
   parameter int NUM_SETS = 64
) (
   input  logic   clk,
   input  logic   rst,
   plru_if.slave  bus
);
   localparam int WW = $clog2(ASSOC);
   localparam int SW = $clog2(NUM_SETS);
   localparam int LW = ASSOC - 1;
   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_TOUCH = 2'b01;
   localparam logic [1:0] OP_PEEK  = 2'b11;

   typedef enum logic {INIT, READY} state_t;

   state_t         state, state_nx;
   logic [SW-1:0]  cnt, cnt_nx;
   logic           ready, init_we;

   logic [LW-1:0]  mem [NUM_SETS];

   logic           s1_valid;
   logic [1:0]     s1_op;
   logic [SW-1:0]  s1_set;
   logic [WW-1:0]  s1_way;
   logic [LW-1:0]  s1_lru;
`ifdef PLRU_INVALID_FIRST_EN
   logic [ASSOC-1:0] s1_vmask;
`endif

   logic [WW-1:0]  tree_vic, sel_way;
   logic [LW-1:0]  new_lru, lru_sh;
   logic           wr_en, accept, fwd, b;
   int             node;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ready    = 1'b0;
      init_we  = 1'b0;
      case (state)
         INIT: begin
            init_we = 1'b1;
            if (cnt == SW'(NUM_SETS - 1)) state_nx = READY;
            else                          cnt_nx   = cnt + 1'b1;
         end
         READY: ready = 1'b1;
         default: state_nx = INIT;
      endcase
   end

   assign bus.req_ready = ready & ~rst;
   assign accept        = bus.req_valid & ready;
   assign wr_en         = s1_valid && (s1_op != OP_PEEK);
   assign fwd           = wr_en && (s1_set == bus.req_set);

   // S2 compute: tree victim walk, optional invalid-way override, then touch walk
   always_comb begin
      node     = 0;
      tree_vic = '0;
      lru_sh   = '0;
      b        = 1'b0;
      for (int l = 0; l < WW; l++) begin
         lru_sh            = s1_lru >> node;
         b                 = ~lru_sh[0];
         tree_vic[WW-1-l]  = b;
         node              = b ? (2 * node + 2) : (2 * node + 1);
      end

      sel_way = tree_vic;
`ifdef PLRU_INVALID_FIRST_EN
      for (int i = ASSOC - 1; i >= 0; i--)
         if (!s1_vmask[i]) sel_way = WW'(i);
`endif
      if (s1_op == OP_TOUCH) sel_way = s1_way;

      new_lru = s1_lru;
      if (s1_op != OP_PEEK) begin
         node = 0;
         for (int l = 0; l < WW; l++) begin
            b       = sel_way[WW-1-l];
            new_lru = (new_lru & ~(LW'(1) << node)) | (LW'(b) << node);
            node    = b ? (2 * node + 2) : (2 * node + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (init_we)    mem[cnt]    <= '0;
         else if (wr_en) mem[s1_set] <= new_lru;
      end
   end

   // S1: register request; same-set write in S2 this cycle is forwarded
   always_ff @(posedge clk) begin
      if (rst) s1_valid <= 1'b0;
      else     s1_valid <= accept && (bus.req_op != OP_NOP);
      if (accept) begin
         s1_op  <= bus.req_op;
         s1_set <= bus.req_set;
         s1_way <= bus.req_way;
         s1_lru <= fwd ? new_lru : mem[bus.req_set];
`ifdef PLRU_INVALID_FIRST_EN
         s1_vmask <= bus.req_vmask;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.resp_valid <= 1'b0;
         bus.resp_way   <= '0;
         bus.resp_lru   <= '0;
      end else begin
         bus.resp_valid <= s1_valid;
         if (s1_valid) begin
            bus.resp_way <= sel_way;
            bus.resp_lru <= new_lru;
         end
      end
   end
endmodule

// File: tb/tb_plru_array.sv
// Scoreboard bench for plru_array (ASSOC=8, NUM_SETS=64); expected responses
// are queued at issue time and popped by a negedge monitor.
module tb_plru_array;
   localparam logic [1:0] NOP = 2'b00, TOUCH = 2'b01, ALLOC = 2'b10, PEEK = 2'b11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;

   typedef struct {
      int    way;
      int    lru;
      int    cyc;
      string name;
   } exp_t;
   exp_t q[$];

   plru_if #(.ASSOC(8), .NUM_SETS(64)) bus ();

   plru_array #(.ASSOC(8), .NUM_SETS(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid) begin
         total++;
         if (q.size() == 0) begin
            $display("FAIL unexpected_resp: got way=%0d lru=%h at cyc %0d, required no response",
                     bus.resp_way, bus.resp_lru, cyc);
         end else begin
            e = q.pop_front();
            if (int'(bus.resp_way) == e.way && int'(bus.resp_lru) == e.lru && cyc == e.cyc)
               passed++;
            else
               $display("FAIL %s: got way=%0d lru=%h cyc=%0d, required way=%0d lru=%h cyc=%0d",
                        e.name, bus.resp_way, bus.resp_lru, cyc, e.way, e.lru, e.cyc);
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got == exp) passed++;
      else $display("FAIL %s: got %0d, required %0d", nm, got, exp);
   endtask

   task automatic issue(input logic [1:0] op, input logic [5:0] set, input logic [2:0] way,
                        input logic [7:0] vm, input bit exp_resp, input int ew, input int el,
                        input string nm);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_set   = set;
      bus.req_way   = way;
`ifdef PLRU_INVALID_FIRST_EN
      bus.req_vmask = vm;
`else
      if (vm == 8'h00) bus.req_way = way;
`endif
      if (exp_resp) q.push_back('{ew, el, cyc + 2, nm});
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      bus.req_op    = NOP;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, int'(bus.req_ready), 0);
      chk({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
      chk({tag, "_resp_way"}, int'(bus.resp_way), 0);
      chk({tag, "_resp_lru"}, int'(bus.resp_lru), 0);
   endtask

   task automatic count_init(input string nm);
      int n = 0;
      @(negedge clk);
      while (!bus.req_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk(nm, n, 64);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = NOP;
      bus.req_set   = '0;
      bus.req_way   = '0;
`ifdef PLRU_INVALID_FIRST_EN
      bus.req_vmask = 8'hFF;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset0");
      rst = 1'b0;
      count_init("init_len_first");

      issue(PEEK,  6'd0, 3'd0, 8'hFF, 1, 7, 'h00, "peek_set0");
      idle(3);
      issue(TOUCH, 6'd5, 3'd7, 8'hFF, 1, 7, 'h45, "touch_s5_w7");
      issue(PEEK,  6'd5, 3'd0, 8'hFF, 1, 3, 'h45, "peek_s5_fwd");
      idle(3);
      issue(ALLOC, 6'd9, 3'd0, 8'hFF, 1, 7, 'h45, "alloc_s9_a");
      issue(ALLOC, 6'd9, 3'd0, 8'hFF, 1, 3, 'h56, "alloc_s9_b_fwd");
      idle(3);
      issue(NOP,   6'd5, 3'd2, 8'hFF, 0, 0, 0,     "nop_s5");
      idle(2);
      issue(PEEK,  6'd5, 3'd0, 8'hFF, 1, 3, 'h45, "peek_s5_after_nop");
      idle(3);

      // ALLOC accepted, then reset while it sits in S1: it must vanish
      issue(ALLOC, 6'd12, 3'd0, 8'hFF, 0, 0, 0, "alloc_dropped");
      rst = 1'b1;
      bus.req_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk_reset("reset_inflight");
      rst = 1'b0;

      // requests during INIT are ignored; reset mid-sweep restarts it
      bus.req_valid = 1'b1;
      bus.req_op    = PEEK;
      bus.req_set   = 6'd0;
      repeat (30) begin @(posedge clk); #1; end
      rst = 1'b1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      count_init("init_len_restart");

      issue(PEEK,  6'd12, 3'd0, 8'hFF, 1, 7, 'h00, "peek_s12_after_rst");
      issue(ALLOC, 6'd9,  3'd0, 8'hFF, 1, 7, 'h45, "alloc_s9_reinit");
      idle(3);
`ifdef PLRU_INVALID_FIRST_EN
      issue(ALLOC, 6'd2, 3'd0, 8'hF7, 1, 3, 'h12, "alloc_invalid_w3");
      issue(ALLOC, 6'd2, 3'd0, 8'hFF, 1, 7, 'h57, "alloc_all_valid");
      idle(3);
`endif
      idle(10);
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/plru_array.md
PLRU_ARRAY -- requirements
Module: plru_array

Interface
REQ-001 SHALL have parameter ASSOC, default 8, ways per set; power of two, >=2.
REQ-002 SHALL have parameter NUM_SETS, default 64, number of sets; power of two, >=2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-007 SHALL have port req_op  input  2  00 NOP, 01 TOUCH, 10 ALLOC, 11 PEEK.
REQ-008 SHALL have port req_set  input  $clog2(NUM_SETS)  set index.
REQ-009 SHALL have port req_way  input  $clog2(ASSOC)  way for TOUCH; ignored otherwise.
REQ-010 SHALL have port resp_valid  output  1  one-cycle pulse per accepted non-NOP request.
REQ-011 SHALL have port resp_way  output  $clog2(ASSOC)  victim way (ALLOC/PEEK), req_way (TOUCH).
REQ-012 SHALL have port resp_lru  output  ASSOC-1  set's tree bits after the operation.

Function
REQ-013 SHALL store ASSOC-1 tree bits per set; node i has children 2i+1 (left) and 2i+2 (right); root is node 0.
REQ-014 TOUCH of way w SHALL walk from root, way bits MSB first: write node bit = current way bit; next node left if bit 0, right if 1; off-path bits unchanged.
REQ-015 Victim SHALL be found by walking from root: way bit = inverted node bit; next node left if way bit 0, right if 1.
REQ-016 ALLOC SHALL return the victim and update the set as a TOUCH of that victim; PEEK SHALL return the victim without updating.
REQ-017 SHALL be a 2-stage pipeline: S1 registers request and reads set array; S2 computes and writes array, registers response; accept in cycle N -> resp_valid in cycle N+2.
REQ-018 SHALL sustain one request per cycle in READY; req_ready SHALL be constant 1 in READY (no backpressure).
REQ-019 When S2 writes set X and S1 holds a request for set X, S2 SHALL forward the written bits so back-to-back same-set requests see updated state.
REQ-020 NOP, or req_valid while req_ready=0, SHALL not change state nor produce resp_valid.
REQ-021 FSM SHALL have states INIT and READY; INIT writes zero to one set per cycle, set counter 0..NUM_SETS-1, then READY; req_ready=0 in INIT.
REQ-022 INIT SHALL last exactly NUM_SETS cycles after rst deasserts.

Reset
REQ-023 While rst=1: state INIT, set counter 0, S1/S2 valid cleared, req_ready=0, resp_valid=0, resp_way=0, resp_lru=0.
REQ-024 rst during INIT SHALL restart the sweep at set 0; rst with requests in flight SHALL drop them with no response.

Configuration
REQ-025 Macro PLRU_INVALID_FIRST_EN defined: SHALL add input req_vmask (ASSOC bits, 1=way valid); ALLOC/PEEK with any mask bit 0 SHALL return the lowest-index invalid way (ALLOC touches it); all ones -> tree victim.
REQ-026 Macro PLRU_INVALID_FIRST_EN undefined: req_vmask port SHALL be absent and the victim is always the tree victim.

Verification (ASSOC=8, NUM_SETS=64)
REQ-027 Release rst -> req_ready=0 exactly 64 cycles, then 1; PEEK set 0 -> resp_way=7, resp_lru=7'h00, two cycles after accept.
REQ-028 TOUCH set 5 way 7 -> resp_lru=7'h45; then PEEK set 5 -> resp_way=3, resp_lru=7'h45.
REQ-029 ALLOC set 9 on two consecutive cycles -> resp_way 7 then 3; second resp_lru=7'h56 (forwarding).
REQ-030 rst pulse at INIT cycle 30 -> req_ready low 64 cycles after release; rst with ALLOC in S1 -> no resp_valid, set unchanged.
REQ-031 req_valid with req_ready=0, and NOP in READY -> no resp_valid; subsequent PEEK shows unchanged bits.
REQ-032 With PLRU_INVALID_FIRST_EN: ALLOC set 2 req_vmask=8'hF7 -> resp_way=3; req_vmask=8'hFF -> tree victim.
